// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus controller:
// address map, UART status bits, FSM and target encodings.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SRAM     = 3'd1,
    FLASH_LO = 3'd2,
    FLASH_HI = 3'd3,
    UART     = 3'd4,
    DONE     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    T_NONE  = 3'd0,
    T_SRAM  = 3'd1,
    T_FLASH = 3'd2,
    T_UDATA = 3'd3,
    T_USTAT = 3'd4
  } tgt_t;

  localparam logic [31:0] SRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] SRAM_MASK  = 32'hFF80_0000;
  localparam logic [31:0] FLASH_BASE = 32'hBE00_0000;
  localparam logic [31:0] FLASH_MASK = 32'hFF00_0000;
  localparam logic [31:0] UART_DATA  = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT  = 32'hBFD0_03FC;

  localparam int ST_TXRDY = 0;
  localparam int ST_RXNE  = 1;
  localparam int ST_OVF   = 2;

  function automatic tgt_t decode(input logic [31:0] a);
    tgt_t t;
    t = T_NONE;
    if ((a & SRAM_MASK) == SRAM_BASE) t = T_SRAM;
    else if ((a & FLASH_MASK) == FLASH_BASE) t = T_FLASH;
    else if (a == UART_DATA) t = T_UDATA;
    else if (a == UART_STAT) t = T_USTAT;
    return t;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;

  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: arbitrates IF/MEM masters onto SRAM,
// flash and UART; one transaction at a time, ack in DONE.
module mem_bus_ctrl
  import bus_pkg::*;
#(
  parameter int SRAM_WAIT  = 1,
  parameter int FLASH_WAIT = 3,
  parameter int RX_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        ram_bank,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [31:0] ram_dq_o,
  output logic        ram_dq_oe,
  input  logic [31:0] ram_dq_i,
  output logic [22:0] flash_a,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  input  logic [15:0] flash_d_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy
);

  localparam logic [7:0] SW = 8'(SRAM_WAIT);
  localparam logic [7:0] FW = 8'(FLASH_WAIT);

  state_t state, state_n;
  tgt_t tgt_q, tgt_n;
  logic [7:0]  cnt;
  logic        own_mem, we_q;
  logic        req_any, req_we, tx_wr;
  logic [3:0]  sel_q;
  logic [21:0] a_q;
  logic [31:0] wd_q, rd_n;
  logic [15:0] lo_q;
  logic        ovf_q, ovf_set, stat_rd;
  logic        rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;

  assign req_any = mem_req | if_req;
  assign req_we  = mem_req & mem_we;
  assign tx_wr   = (tgt_q == T_UDATA) && we_q;
  assign ovf_set = rx_ready && rx_full && !rx_pop;

  // IF never touches the UART: its accesses there act unmapped
  always_comb begin
    tgt_n = decode(mem_req ? mem_addr : if_addr);
    if (!mem_req && (tgt_n == T_UDATA || tgt_n == T_USTAT))
      tgt_n = T_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 8'd1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_any) begin
        if (tgt_n == T_SRAM) state_n = SRAM;
        else if (tgt_n == T_FLASH && !req_we) state_n = FLASH_LO;
        else state_n = UART;
      end
      SRAM:     if (cnt == SW) state_n = DONE;
      FLASH_LO: if (cnt == FW) state_n = FLASH_HI;
      FLASH_HI: if (cnt == FW) state_n = DONE;
      UART:     if (!tx_wr || tx_start) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_ce_n   = 1'b1;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    ram_dq_oe  = 1'b0;
    ram_be_n   = 4'hF;
    flash_ce_n = 1'b1;
    flash_oe_n = 1'b1;
    if_ack     = 1'b0;
    mem_ack    = 1'b0;
    rx_pop     = 1'b0;
    stat_rd    = 1'b0;
    rd_n       = '0;
    unique case (state)
      SRAM: begin
        ram_ce_n  = 1'b0;
        ram_be_n  = ~sel_q;
        ram_oe_n  = we_q;
        ram_we_n  = !we_q || cnt == SW;
        ram_dq_oe = we_q;
        if (!we_q) rd_n = ram_dq_i;
      end
      FLASH_LO: begin
        flash_ce_n = 1'b0;
        flash_oe_n = 1'b0;
      end
      FLASH_HI: begin
        flash_ce_n = 1'b0;
        flash_oe_n = 1'b0;
        rd_n       = {flash_d_i, lo_q};
      end
      UART: if (!we_q) begin
        if (tgt_q == T_UDATA) begin
          rx_pop    = !rx_empty;
          rd_n[7:0] = rx_empty ? 8'h00 : rx_head;
        end
        if (tgt_q == T_USTAT) begin
          stat_rd        = 1'b1;
          rd_n[ST_OVF]   = ovf_q;
          rd_n[ST_RXNE]  = !rx_empty;
          rd_n[ST_TXRDY] = !tx_busy;
        end
      end
      DONE: begin
        if_ack  = !own_mem;
        mem_ack = own_mem;
      end
      default: ;
    endcase
  end

  assign ram_bank = a_q[20];
  assign ram_addr = a_q[19:0];
  assign ram_dq_o = wd_q;
  assign flash_a  = {a_q, state == FLASH_HI};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_mem   <= 1'b0;
      we_q      <= 1'b0;
      tgt_q     <= T_NONE;
      sel_q     <= '0;
      a_q       <= '0;
      wd_q      <= '0;
      lo_q      <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (state == IDLE && req_any) begin
        own_mem <= mem_req;
        we_q    <= req_we;
        tgt_q   <= tgt_n;
        sel_q   <= mem_req ? mem_sel : 4'hF;
        a_q     <= mem_req ? mem_addr[23:2] : if_addr[23:2];
        wd_q    <= mem_req ? mem_wdata : '0;
        if (req_we && tgt_n == T_UDATA) tx_data <= mem_wdata[7:0];
      end
      if (state == FLASH_LO && cnt == FW) lo_q <= flash_d_i;
      // rdata only changes on the edge into this master's ack
      if (state_n == DONE) begin
        if (own_mem) mem_rdata <= rd_n;
        else         if_rdata  <= rd_n;
      end
      tx_start <= state == UART && tx_wr && !tx_busy && !tx_start;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (stat_rd) ovf_q <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_ready),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with default parameters
// (SRAM_WAIT=1, FLASH_WAIT=3, RX_DEPTH=4).
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = 4'hF;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        ram_bank;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  logic [31:0] ram_dq_o;
  logic        ram_dq_oe;
  logic [31:0] ram_dq_i = '0;
  logic [22:0] flash_a;
  logic        flash_ce_n, flash_oe_n;
  logic [15:0] flash_d_i;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  assign flash_d_i = flash_a[0] ? 16'hABCD : 16'h1234;

  always @(negedge clk)
    if (!ram_ce_n || !flash_ce_n) strobe_cnt++;

  mem_bus_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .ram_bank   (ram_bank),
    .ram_addr   (ram_addr),
    .ram_be_n   (ram_be_n),
    .ram_ce_n   (ram_ce_n),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n),
    .ram_dq_o   (ram_dq_o),
    .ram_dq_oe  (ram_dq_oe),
    .ram_dq_i   (ram_dq_i),
    .flash_a    (flash_a),
    .flash_ce_n (flash_ce_n),
    .flash_oe_n (flash_oe_n),
    .flash_d_i  (flash_d_i),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy)
  );

  task automatic wait_ack(input bit m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m ? mem_ack : if_ack) && n < 60);
    if (!(m ? mem_ack : if_ack)) n = -1;
  endtask

  task automatic do_mem(input logic [31:0] a, input logic we,
                        input logic [31:0] wd, output int n);
    mem_addr = a; mem_we = we; mem_wdata = wd;
    mem_sel = 4'hF; mem_req = 1'b1;
    wait_ack(1'b1, n);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, flash_ce_n, flash_oe_n, ram_be_n} !== 9'h1FF) begin
      errors++;
      $display("FAIL reset_strobes: got %h want 1ff",
        {ram_ce_n, ram_oe_n, ram_we_n, flash_ce_n, flash_oe_n, ram_be_n});
    end
    checks++;
    if ({ram_bank, ram_addr, flash_a, ram_dq_o, tx_data} !== '0) begin
      errors++;
      $display("FAIL reset_addr: bank=%b addr=%h fa=%h dq=%h tx=%h want 0",
        ram_bank, ram_addr, flash_a, ram_dq_o, tx_data);
    end
    checks++;
    if ({if_rdata, mem_rdata, if_ack, mem_ack, tx_start, ram_dq_oe} !== '0) begin
      errors++;
      $display("FAIL reset_data: ird=%h mrd=%h ia=%b ma=%b ts=%b oe=%b want 0",
        if_rdata, mem_rdata, if_ack, mem_ack, tx_start, ram_dq_oe);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_ce_n, flash_ce_n, mem_ack, if_ack} !== 4'b1100) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 1100",
        {ram_ce_n, flash_ce_n, mem_ack, if_ack});
    end
  endtask

  task automatic test_sram_read;
    int n, oe, ack_n;
    logic bank;
    logic [19:0] ra;
    ram_dq_i = 32'hCAFE_BABE;
    mem_addr = 32'h8040_0010; mem_we = 1'b0; mem_sel = 4'hF;
    mem_req = 1'b1;
    n = 0; oe = 0; ack_n = -1; bank = 1'b0; ra = '0;
    while (n < 20 && ack_n < 0) begin
      @(negedge clk);
      n++;
      if (!ram_oe_n) oe++;
      if (!ram_ce_n) begin bank = ram_bank; ra = ram_addr; end
      if (mem_ack) ack_n = n;
    end
    mem_req = 1'b0;
    ram_dq_i = 32'h0;
    checks++;
    if (ack_n !== 3) begin errors++; $display("FAIL sram_rd_latency: got %0d want 3", ack_n); end
    checks++;
    if (oe !== 2) begin errors++; $display("FAIL sram_rd_oe_cycles: got %0d want 2", oe); end
    checks++;
    if (bank !== 1'b1) begin errors++; $display("FAIL sram_rd_bank: got %b want 1", bank); end
    checks++;
    if (ra !== 20'h00004) begin errors++; $display("FAIL sram_rd_addr: got %h want 00004", ra); end
    checks++;
    if (mem_rdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL sram_rd_data: got %h want cafebabe", mem_rdata); end
    @(negedge clk);
    checks++;
    if (mem_ack !== 1'b0) begin errors++; $display("FAIL sram_rd_ack_width: got %b want 0", mem_ack); end
    checks++;
    if (mem_rdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL sram_rd_hold: got %h want cafebabe", mem_rdata); end
  endtask

  task automatic test_sram_write;
    int n, ce, we, dqoe, oe, ack_n;
    logic [3:0] be;
    logic [31:0] dq;
    logic [19:0] ra;
    mem_addr = 32'h8000_0100; mem_we = 1'b1; mem_sel = 4'b0011;
    mem_wdata = 32'h1234_5678; mem_req = 1'b1;
    n = 0; ce = 0; we = 0; dqoe = 0; oe = 0; ack_n = -1;
    be = 4'h0; dq = '0; ra = '0;
    while (n < 20 && ack_n < 0) begin
      @(negedge clk);
      n++;
      if (!ram_ce_n) begin ce++; be = ram_be_n; dq = ram_dq_o; ra = ram_addr; end
      if (!ram_we_n) we++;
      if (!ram_oe_n) oe++;
      if (ram_dq_oe) dqoe++;
      if (mem_ack) ack_n = n;
    end
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'hF;
    @(negedge clk);
    checks++;
    if (ack_n !== 3) begin errors++; $display("FAIL sram_wr_latency: got %0d want 3", ack_n); end
    checks++;
    if ({ce, we, dqoe, oe} !== {32'd2, 32'd1, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL sram_wr_strobes: ce=%0d we=%0d dqoe=%0d oe=%0d want 2 1 2 0", ce, we, dqoe, oe);
    end
    checks++;
    if (be !== 4'b1100) begin errors++; $display("FAIL sram_wr_be: got %b want 1100", be); end
    checks++;
    if (dq !== 32'h1234_5678) begin errors++; $display("FAIL sram_wr_dq: got %h want 12345678", dq); end
    checks++;
    if (ra !== 20'h00040) begin errors++; $display("FAIL sram_wr_addr: got %h want 00040", ra); end
  endtask

  task automatic test_arb;
    int n, mack, iack, both;
    logic [3:0] ibe;
    ram_dq_i = 32'h1111_1111;
    mem_addr = 32'h8000_0000; mem_we = 1'b0; mem_sel = 4'hF;
    if_addr = 32'h8000_0004;
    mem_req = 1'b1; if_req = 1'b1;
    n = 0; mack = -1; iack = -1; both = 0; ibe = 4'hF;
    while (n < 30 && iack < 0) begin
      @(negedge clk);
      n++;
      if (mem_ack && if_ack) both++;
      if (!ram_ce_n && mack >= 0) ibe = ram_be_n;
      if (mem_ack) begin mack = n; mem_req = 1'b0; ram_dq_i = 32'h2222_2222; end
      if (if_ack) begin iack = n; if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mack !== 3) begin errors++; $display("FAIL arb_mem_first: got %0d want 3", mack); end
    checks++;
    if (iack !== 7) begin errors++; $display("FAIL arb_if_latency: got %0d want 7", iack); end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL arb_dual_ack: got %0d want 0", both); end
    checks++;
    if (ibe !== 4'b0000) begin errors++; $display("FAIL arb_if_be: got %b want 0000", ibe); end
    checks++;
    if (if_rdata !== 32'h2222_2222) begin errors++; $display("FAIL arb_if_data: got %h want 22222222", if_rdata); end
    checks++;
    if (mem_rdata !== 32'h1111_1111) begin errors++; $display("FAIL arb_mem_hold: got %h want 11111111", mem_rdata); end
  endtask

  task automatic test_flash;
    int n, ce, ack_n;
    logic [22:0] alo, ahi;
    mem_addr = 32'hBE00_0008; mem_we = 1'b0; mem_req = 1'b1;
    n = 0; ce = 0; ack_n = -1; alo = '1; ahi = '1;
    while (n < 30 && ack_n < 0) begin
      @(negedge clk);
      n++;
      if (!flash_ce_n && !flash_oe_n) begin
        ce++;
        if (flash_a[0]) ahi = flash_a; else alo = flash_a;
      end
      if (mem_ack) ack_n = n;
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_n !== 9) begin errors++; $display("FAIL flash_latency: got %0d want 9", ack_n); end
    checks++;
    if (ce !== 8) begin errors++; $display("FAIL flash_strobe_cycles: got %0d want 8", ce); end
    checks++;
    if ({alo, ahi} !== {23'd4, 23'd5}) begin errors++; $display("FAIL flash_addr: got %h %h want 4 5", alo, ahi); end
    checks++;
    if (mem_rdata !== 32'hABCD_1234) begin errors++; $display("FAIL flash_data: got %h want abcd1234", mem_rdata); end
    strobe_cnt = 0;
    do_mem(32'hBE00_0010, 1'b1, 32'h5555_AAAA, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL flash_wr_latency: got %0d want 2", n); end
    checks++;
    if (strobe_cnt !== 0) begin errors++; $display("FAIL flash_wr_strobes: got %0d want 0", strobe_cnt); end
  endtask

  task automatic test_uart_tx;
    int n, starts, sk, ack_n;
    logic [7:0] td;
    tx_busy = 1'b1;
    mem_addr = 32'hBFD0_03F8; mem_we = 1'b1; mem_wdata = 32'h0000_0141;
    mem_req = 1'b1;
    n = 0; starts = 0; sk = -1; ack_n = -1; td = '0;
    while (n < 30 && ack_n < 0) begin
      @(negedge clk);
      n++;
      if (tx_start) begin starts++; sk = n; td = tx_data; end
      if (mem_ack) ack_n = n;
      if (n == 5) tx_busy = 1'b0;
    end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    if (tx_start) starts++;
    checks++;
    if (starts !== 1) begin errors++; $display("FAIL tx_start_count: got %0d want 1", starts); end
    checks++;
    if (sk !== 6) begin errors++; $display("FAIL tx_start_cycle: got %0d want 6", sk); end
    checks++;
    if (td !== 8'h41) begin errors++; $display("FAIL tx_data: got %h want 41", td); end
    checks++;
    if (ack_n !== 7) begin errors++; $display("FAIL tx_ack_cycle: got %0d want 7", ack_n); end
  endtask

  task automatic test_rx_fifo;
    int n;
    logic [7:0] exp_b [5];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'h11 * (i + 1));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    do_mem(32'hBFD0_03FC, 1'b0, '0, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL stat_latency: got %0d want 2", n); end
    checks++;
    if (mem_rdata !== 32'h6) begin errors++; $display("FAIL stat_ovf_busy: got %h want 6", mem_rdata); end
    tx_busy = 1'b0;
    do_mem(32'hBFD0_03FC, 1'b0, '0, n);
    checks++;
    if (mem_rdata !== 32'h3) begin errors++; $display("FAIL stat_ovf_cleared: got %h want 3", mem_rdata); end
    for (int i = 0; i < 5; i++) begin
      do_mem(32'hBFD0_03F8, 1'b0, '0, n);
      checks++;
      if (n !== 2 || mem_rdata !== {24'h0, exp_b[i]}) begin
        errors++;
        $display("FAIL rx_read_%0d: got %h lat %0d want %h lat 2", i, mem_rdata, n, exp_b[i]);
      end
    end
    do_mem(32'hBFD0_03FC, 1'b0, '0, n);
    checks++;
    if (mem_rdata !== 32'h1) begin errors++; $display("FAIL stat_empty: got %h want 1", mem_rdata); end
  endtask

  task automatic test_if_uart_unmapped;
    int n;
    rx_data = 8'h99; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    if_addr = 32'hBFD0_03F8; if_req = 1'b1;
    wait_ack(1'b0, n);
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (n !== 2 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL if_uart: got %h lat %0d want 0 lat 2", if_rdata, n);
    end
    do_mem(32'hBFD0_03F8, 1'b0, '0, n);
    checks++;
    if (mem_rdata !== 32'h99) begin errors++; $display("FAIL if_no_pop: got %h want 99", mem_rdata); end
    strobe_cnt = 0;
    do_mem(32'h1000_0000, 1'b0, '0, n);
    checks++;
    if (n !== 2 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_rd: got %h lat %0d want 0 lat 2", mem_rdata, n);
    end
    checks++;
    if (strobe_cnt !== 0) begin errors++; $display("FAIL unmapped_strobes: got %0d want 0", strobe_cnt); end
  endtask

  task automatic test_reset_mid;
    int n, acks;
    mem_addr = 32'h8000_0200; mem_we = 1'b1; mem_wdata = 32'hDEAD_BEEF;
    mem_sel = 4'hF; mem_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_we_n, ram_ce_n} !== 2'b00) begin errors++; $display("FAIL mid_strobe_active: got %b want 00", {ram_we_n, ram_ce_n}); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ram_we_n, ram_ce_n, ram_dq_oe} !== 3'b110) begin
      errors++;
      $display("FAIL mid_reset_release: got %b want 110", {ram_we_n, ram_ce_n, ram_dq_oe});
    end
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d want 0", acks); end
    ram_dq_i = 32'h5A5A_5A5A;
    do_mem(32'h8000_0000, 1'b0, '0, n);
    checks++;
    if (n !== 3 || mem_rdata !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL mid_next_req: got %h lat %0d want 5a5a5a5a lat 3", mem_rdata, n);
    end
  endtask

  initial begin
    test_reset;
    test_sram_read;
    test_sram_write;
    test_arb;
    test_flash;
    test_uart_tx;
    test_rx_fifo;
    test_if_uart_unmapped;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
